// File: rtl/cnt_pkg.sv
// cnt_pkg: shared counter command encoding and load clamp helper
package cnt_pkg;
  typedef enum logic [1:0] {CMD_HOLD, CMD_CLR, CMD_LOAD, CMD_STEP} cnt_cmd_e;
  function automatic int unsigned clamp_mod(input int unsigned val, input int unsigned modulo);
    return (val >= modulo) ? modulo - 1 : val;
  endfunction
endpackage

// File: rtl/mod_counter_next.sv
// mod_counter_next: combinational next-count and terminal-count logic
//  count    in   WIDTH  current registered count
//  clr      in   1      clear command (highest priority)
//  load     in   1      load command
//  load_val in   WIDTH  value to load, clamped to MODULO-1
//  en       in   1      step command (lowest priority)
//  up_dn    in   1      1 = up, 0 = down
//  count_d  out  WIDTH  next count
//  tc       out  1      step taken at the terminal value (cascade output, ovf set)
module mod_counter_next
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] count,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count_d,
  output logic             tc
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULO - 1);
  localparam bit SAT = SATURATE != 0;
  // a full binary range wraps by plain overflow of the adder
  localparam bit FULL = 64'(MODULO) == (64'd1 << WIDTH);
  cnt_cmd_e         cmd;
  logic             at_term;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] ld;
  always_comb begin
    cmd     = clr ? CMD_CLR : load ? CMD_LOAD : en ? CMD_STEP : CMD_HOLD;
    at_term = count == (up_dn ? TOP : '0);
    tc      = (cmd == CMD_STEP) && at_term;
    step    = (at_term && SAT) ? count :
              (at_term && !FULL) ? (up_dn ? '0 : TOP) :
              up_dn ? count + WIDTH'(1) : count - WIDTH'(1);
    ld      = WIDTH'(clamp_mod(32'(load_val), MODULO));
    count_d = (cmd == CMD_CLR) ? '0 : (cmd == CMD_LOAD) ? ld : (cmd == CMD_STEP) ? step : count;
  end
endmodule

// File: rtl/mod_counter.sv
// mod_counter: synchronous up/down modulo counter with load, saturate, cascade tc and sticky ovf
//  clk      in   1      clock, rising edge
//  rstn     in   1      asynchronous active-low reset
//  clr      in   1      synchronous clear of count and ovf
//  load     in   1      synchronous load of load_val (clamped)
//  load_val in   WIDTH  value to load
//  en       in   1      count enable / cascade input
//  up_dn    in   1      1 = up, 0 = down
//  count    out  WIDTH  registered count
//  tc       out  1      combinational terminal count
//  ovf      out  1      sticky wrap/saturation flag
module mod_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);
  if (WIDTH < 1 || MODULO < 2 || 64'(MODULO) > (64'd1 << WIDTH)) begin : g_bad_param
    $error("mod_counter: MODULO %0d out of range for WIDTH %0d", MODULO, WIDTH);
  end
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  mod_counter_next #(.WIDTH(WIDTH), .MODULO(MODULO), .SATURATE(SATURATE)) u_next (
    .count   (count_q),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .en      (en),
    .up_dn   (up_dn),
    .count_d (count_d),
    .tc      (tc)
  );
  // tc already excludes clr/load, so it marks exactly the wrap/saturation steps
  assign ovf_d = clr ? 1'b0 : ovf_q | tc;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
  assign count = count_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed self-checking bench for mod_counter
module tb_mod_counter;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  logic w_clr = 0, w_load = 0, w_en = 0, w_up = 1, w_tc, w_ovf;
  logic [3:0] w_lv = 0, w_cnt;
  logic s_clr = 0, s_load = 0, s_en = 0, s_up = 1, s_tc, s_ovf;
  logic [3:0] s_lv = 0, s_cnt;
  logic c_en = 0, c0_tc, c0_ovf, c1_tc, c1_ovf;
  logic [3:0] c0_cnt, c1_cnt;
  int n_chk = 0, n_fail = 0;
  int e0, e1, exp_c;
  mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0)) u_w (
    .clk(clk), .rstn(rstn), .clr(w_clr), .load(w_load), .load_val(w_lv), .en(w_en),
    .up_dn(w_up), .count(w_cnt), .tc(w_tc), .ovf(w_ovf));
  mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1)) u_s (
    .clk(clk), .rstn(rstn), .clr(s_clr), .load(s_load), .load_val(s_lv), .en(s_en),
    .up_dn(s_up), .count(s_cnt), .tc(s_tc), .ovf(s_ovf));
  mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0)) u_c0 (
    .clk(clk), .rstn(rstn), .clr(1'b0), .load(1'b0), .load_val(4'd0), .en(c_en),
    .up_dn(1'b1), .count(c0_cnt), .tc(c0_tc), .ovf(c0_ovf));
  mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0)) u_c1 (
    .clk(clk), .rstn(rstn), .clr(1'b0), .load(1'b0), .load_val(4'd0), .en(c0_tc),
    .up_dn(1'b1), .count(c1_cnt), .tc(c1_tc), .ovf(c1_ovf));
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    #2 rstn = 1'b0;
    #2 rstn = 1'b1;
  endtask
  initial begin
    #3;
    chk("rst_w_cnt", int'(w_cnt), 0);
    chk("rst_w_ovf", int'(w_ovf), 0);
    chk("rst_s_cnt", int'(s_cnt), 0);
    chk("rst_c1_cnt", int'(c1_cnt), 0);
    chk("rst_tc_idle", int'(w_tc), 0);
    rstn = 1'b1;
    // 1: wrap up count
    w_en = 1; w_up = 1; exp_c = 0;
    for (int i = 0; i < 11; i++) begin
      #1 chk("t1_tc", int'(w_tc), (exp_c == 9) ? 1 : 0);
      tick();
      exp_c = (exp_c + 1) % 10;
      chk("t1_cnt", int'(w_cnt), exp_c);
      chk("t1_ovf", int'(w_ovf), (i >= 9) ? 1 : 0);
    end
    // 2: down from reset wraps to 9
    w_en = 0;
    pulse_reset();
    chk("t2_rst_ovf", int'(w_ovf), 0);
    w_up = 0; w_en = 1;
    #1 chk("t2_tc0", int'(w_tc), 1);
    tick();
    chk("t2_cnt9", int'(w_cnt), 9);
    chk("t2_ovf", int'(w_ovf), 1);
    chk("t2_tc9", int'(w_tc), 0);
    tick();
    chk("t2_cnt8", int'(w_cnt), 8);
    w_up = 1;
    tick();
    chk("t2_dirchg", int'(w_cnt), 9);
    // 3: saturate
    s_load = 1; s_lv = 8; s_en = 1;
    #1 chk("t3_tc_load", int'(s_tc), 0);
    tick();
    chk("t3_load8", int'(s_cnt), 8);
    s_load = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_sat_cnt", int'(s_cnt), 9);
      chk("t3_sat_tc", int'(s_tc), 1);
      chk("t3_sat_ovf", int'(s_ovf), (i >= 1) ? 1 : 0);
    end
    s_clr = 1;
    #1 chk("t3_tc_clr", int'(s_tc), 0);
    tick();
    chk("t3_clr_cnt", int'(s_cnt), 0);
    chk("t3_clr_ovf", int'(s_ovf), 0);
    s_clr = 0; s_up = 0;
    tick();
    chk("t3_sat_dn0", int'(s_cnt), 0);
    chk("t3_sat_dn_ovf", int'(s_ovf), 1);
    s_en = 0;
    // 4: load clamp keeps ovf, clr beats load
    w_en = 1; w_load = 1; w_lv = 15;
    tick();
    chk("t4_clamp", int'(w_cnt), 9);
    chk("t4_ovf_kept", int'(w_ovf), 1);
    w_clr = 1; w_lv = 5;
    tick();
    chk("t4_clr_load", int'(w_cnt), 0);
    chk("t4_clr_ovf", int'(w_ovf), 0);
    w_clr = 0; w_lv = 12;
    tick();
    chk("t4_clamp_ovf0", int'(w_cnt), 9);
    chk("t4_load_no_ovf", int'(w_ovf), 0);
    w_lv = 3;
    tick();
    chk("t4_load3", int'(w_cnt), 3);
    w_load = 0; w_en = 0;
    tick();
    chk("t4_hold", int'(w_cnt), 3);
    // 5: cascade
    c_en = 1; e0 = 0; e1 = 0;
    for (int i = 0; i < 105; i++) begin
      #1 chk("t5_tc0", int'(c0_tc), (e0 == 9) ? 1 : 0);
      tick();
      if (e0 == 9) e1 = (e1 + 1) % 10;
      e0 = (e0 + 1) % 10;
      chk("t5_pair", int'({c1_cnt, c0_cnt}), e1 * 16 + e0);
    end
    chk("t5_final", int'({c1_cnt, c0_cnt}), 8'h05);
    chk("t5_c1_ovf", int'(c1_ovf), 1);
    c_en = 0;
    // 6: async reset mid-count with ovf set
    w_load = 1; w_lv = 9; w_up = 1; w_en = 1;
    tick();
    w_load = 0;
    for (int i = 0; i < 7; i++) tick();
    chk("t6_cnt6", int'(w_cnt), 6);
    chk("t6_ovf1", int'(w_ovf), 1);
    #2 rstn = 1'b0;
    #1 chk("t6_async_cnt", int'(w_cnt), 0);
    chk("t6_async_ovf", int'(w_ovf), 0);
    #2 rstn = 1'b1;
    tick();
    chk("t6_resume", int'(w_cnt), 1);
    tick();
    chk("t6_resume2", int'(w_cnt), 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
